// File: rtl/reaction_pkg.sv
// reaction_pkg
//   Shared types and constants for the reaction-time game engine:
//   FSM state and status encodings, the per-difficulty delay/limit tables
//   and the delay LFSR feedback.
//   No ports (package).

package reaction_pkg;

  localparam int MS_W = 14;

  // Galois feedback for taps 16,14,13,11 in a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    GO    = 2'd2,
    SHOW  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_FALSE = 2'd1,
    ST_SLOW  = 2'd2
  } status_e;

  // Difficulty 3 behaves exactly like difficulty 2.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? 2'd2 : mode;
  endfunction

  // Fixed part of the pre-stimulus wait, in ms.
  function automatic logic [MS_W-1:0] mode_base(input logic [1:0] mode);
    case (mode)
      2'd0:    return 14'd2000;
      2'd1:    return 14'd1000;
      default: return 14'd500;
    endcase
  endfunction

  // Mask applied to the LFSR low bits to form the random part of the wait.
  function automatic logic [10:0] mode_mask(input logic [1:0] mode);
    case (mode)
      2'd0, 2'd1: return 11'h7FF;
      default:    return 11'h3FF;
    endcase
  endfunction

  // Longest allowed reaction before the trial is scored as too slow.
  function automatic logic [MS_W-1:0] mode_limit(input logic [1:0]      mode,
                                                 input logic [MS_W-1:0] max_ms);
    case (mode)
      2'd0:    return max_ms;
      2'd1:    return 14'd1000;
      default: return 14'd500;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_core_if.sv
// reaction_core_if
//   Menu/display-facing signal group of the reaction engine.
//   master : menu/button side (drives start, mode, react, ack)
//   slave  : reaction_core (drives led, busy, done, status, result_ms)
//   start     - menu select level, trial begins on its rising edge
//   mode      - difficulty 0..2 (3 acts as 2)
//   react     - debounced one-cycle button pulse
//   ack       - one-cycle pulse releasing the held result
//   led       - stimulus light
//   busy      - trial in progress (waiting or stimulus lit)
//   done      - one-cycle pulse when a result becomes available
//   status    - 0 ok, 1 false start, 2 too slow
//   result_ms - reaction time in ms

interface reaction_core_if;
  import reaction_pkg::*;

  logic            start;
  logic [1:0]      mode;
  logic            react;
  logic            ack;
  logic            led;
  logic            busy;
  logic            done;
  logic [1:0]      status;
  logic [MS_W-1:0] result_ms;

  modport master (
    output start, mode, react, ack,
    input  led, busy, done, status, result_ms
  );

  modport slave (
    input  start, mode, react, ack,
    output led, busy, done, status, result_ms
  );

endinterface

// File: rtl/ms_tick_gen.sv
// ms_tick_gen
//   Millisecond prescaler. Counts 0..TICK_DIV-1 and flags the last count.
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   clr  - synchronous restart of the count from zero
//   tick - high for one cycle every TICK_DIV cycles

module ms_tick_gen
  import reaction_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == TC)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == TC);

endmodule

// File: rtl/reaction_core.sv
// reaction_core
//   Runs one reaction-time trial: random mode-dependent wait, stimulus
//   LED, measurement of the press in ms, and a held result until ack.
//   clk - system clock
//   rst - asynchronous active-low reset
//   bus - reaction_core_if.slave (start/mode/react/ack in,
//         led/busy/done/status/result_ms out)
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for a start rising edge
//   ARMED | random wait running, LED dark; a press is a false start
//   GO    | LED lit, counting ms until press or limit
//   SHOW  | result held on status/result_ms until ack

module reaction_core
  import reaction_pkg::*;
#(
  parameter int          TICK_DIV  = 100000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_MS    = 9999
) (
  input  logic           clk,
  input  logic           rst,
  reaction_core_if.slave bus
);

  localparam logic [MS_W-1:0] MAX_MS_V = MS_W'(MAX_MS);

  state_e          state_q, state_d;
  logic            start_d_q;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [1:0]      mode_q, mode_d;
  logic [MS_W-1:0] delay_q, delay_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic            led_q, led_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      status_q, status_d;
  logic [MS_W-1:0] result_q, result_d;

  logic            tick;
  logic            clr;
  logic            start_edge;
  logic [1:0]      mode_n;
  logic [MS_W-1:0] limit;
  logic [MS_W-1:0] ms_inc;

  // Prescaler restarts on every state change so the first tick of a
  // state lands a full ms after entry.
  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign start_edge = bus.start & ~start_d_q;
  assign mode_n     = norm_mode(bus.mode);
  assign limit      = mode_limit(mode_q, MAX_MS_V);
  assign lfsr_d     = lfsr_step(lfsr_q);
  assign clr        = (state_d != state_q);

  // Counter value including this cycle's tick; decisions and the reported
  // time use it so a press on a tick cycle counts that tick.
  always_comb begin
    ms_inc = ms_q;
    if (tick && (ms_q != MAX_MS_V)) begin
      ms_inc = ms_q + MS_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    delay_d  = delay_q;
    ms_d     = ms_q;
    status_d = status_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d  = ARMED;
          mode_d   = mode_n;
          delay_d  = mode_base(mode_n) + MS_W'(lfsr_q[10:0] & mode_mask(mode_n));
          status_d = ST_OK;
          result_d = '0;
        end
      end

      ARMED: begin
        ms_d = ms_inc;
        // A press wins over the wait expiring in the same cycle.
        if (bus.react) begin
          state_d  = SHOW;
          status_d = ST_FALSE;
          result_d = '0;
        end else if (tick && (ms_inc == delay_q)) begin
          state_d = GO;
        end
      end

      GO: begin
        ms_d = ms_inc;
        // A press on the limit cycle still scores as a valid reaction.
        if (bus.react) begin
          state_d  = SHOW;
          status_d = ST_OK;
          result_d = ms_inc;
        end else if (ms_inc >= limit) begin
          state_d  = SHOW;
          status_d = ST_SLOW;
          result_d = limit;
        end
      end

      SHOW: begin
        if (bus.ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      ms_d = '0;
    end
  end

  assign led_d  = (state_d == GO);
  assign busy_d = (state_d == ARMED) || (state_d == GO);
  assign done_d = (state_d == SHOW) && (state_q != SHOW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      start_d_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      mode_q    <= 2'd0;
      delay_q   <= '0;
      ms_q      <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= 2'd0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      start_d_q <= bus.start;
      lfsr_q    <= lfsr_d;
      mode_q    <= mode_d;
      delay_q   <= delay_d;
      ms_q      <= ms_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      status_q  <= status_d;
      result_q  <= result_d;
    end
  end

  assign bus.led       = led_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.status    = status_q;
  assign bus.result_ms = result_q;

endmodule

// File: tb/tb_reaction_core.sv
// tb_reaction_core
//   Randomized scoreboard bench for reaction_core with TICK_DIV=4.
//   Expected outcomes are computed from the game rules (cycle counts,
//   per-mode tables, LFSR sequence) and queued when a trial starts;
//   a monitor pops and compares on every done pulse.

module tb_reaction_core;
  import reaction_pkg::*;

  localparam int          TICK_DIV = 4;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam int          MAX_MS   = 9999;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reaction_core_if bus ();

  reaction_core #(
    .TICK_DIV  (TICK_DIV),
    .LFSR_SEED (SEED),
    .MAX_MS    (MAX_MS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int status;
    int result;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;         // clock edges since reset release
  int   led_cycles = 0;  // cycles the LED has been observed lit
  int   pos = 0;         // clock edges since the current trial's start

  int base_t[3] = '{2000, 1000, 500};
  int mask_t[3] = '{2047, 2047, 1023};
  int lim_t[3]  = '{MAX_MS, 1000, 500};

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (bus.led) led_cycles <= led_cycles + 1;
  end

  // LFSR contents after n advances from the seed
  function automatic int lfsr_at(input int n);
    int v;
    v = int'(SEED);
    for (int i = 0; i < n; i++) begin
      v = (v >> 1) ^ (((v & 1) != 0) ? 'hB400 : 0);
    end
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic goto(input int target);
    while (pos < target) begin
      @(posedge clk);
      #1;
      pos++;
    end
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.done) begin
        if (exp_q.size() == 0) begin
          chk("done_without_expect", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("status", int'(bus.status), e.status);
          chk("result_ms", int'(bus.result_ms), e.result);
        end
      end
    end
  end

  // kind 0: press `param` edges after the LED lights
  // kind 1: press sampled `param` edges after ARMED entry (clamped to expiry)
  // kind 2: never press
  task automatic run_trial(input int mode, input int kind, input int param, input bit glitch);
    int   m, lv, d, lim, g, s, smp, leds0;
    exp_t e;
    m   = (mode == 3) ? 2 : mode;
    lv  = lfsr_at(cyc);
    d   = base_t[m] + ((lv & 'h7FF) & mask_t[m]);
    lim = lim_t[m];
    g   = 1 + TICK_DIV * d;
    pos = 0;

    case (kind)
      0:       begin e.status = 0; e.result = (param + 1) / TICK_DIV; end
      1:       begin e.status = 1; e.result = 0; end
      default: begin e.status = 2; e.result = lim; end
    endcase

    chk("busy_before_start", int'(bus.busy), 0);
    exp_q.push_back(e);
    bus.mode  = mode[1:0];
    bus.start = 1'b1;
    goto(1);
    bus.start = 1'b0;
    chk("busy_after_start", int'(bus.busy), 1);
    leds0 = led_cycles;

    if (glitch) begin
      goto(3); bus.start = 1'b1;
      goto(4); bus.start = 1'b0;
      goto(6); bus.start = 1'b1;
      goto(8); bus.start = 1'b0;
    end

    if (kind == 1) begin
      s   = (param > TICK_DIV * d) ? TICK_DIV * d : param;
      smp = 1 + s;
      goto(smp - 1); bus.react = 1'b1;
      goto(smp);     bus.react = 1'b0;
      chk("led_never_lit", led_cycles - leds0, 0);
    end else begin
      goto(g - 1);
      chk("led_before_delay", int'(bus.led), 0);
      goto(g);
      chk("led_at_delay", int'(bus.led), 1);
      if (kind == 0) begin
        smp = g + param + 1;
        goto(smp - 1); bus.react = 1'b1;
        goto(smp);     bus.react = 1'b0;
      end else begin
        smp = g + TICK_DIV * lim;
        goto(smp);
      end
    end

    chk("done_on_result", int'(bus.done), 1);
    chk("led_off_in_show", int'(bus.led), 0);
    chk("busy_off_in_show", int'(bus.busy), 0);

    if (glitch) begin
      goto(smp + 1); bus.react = 1'b1; bus.start = 1'b1;
      goto(smp + 2); bus.react = 1'b0; bus.start = 1'b0;
    end

    goto(smp + 5);
    chk("done_single_pulse", int'(bus.done), 0);
    chk("hold_status", int'(bus.status), e.status);
    chk("hold_result", int'(bus.result_ms), e.result);
    bus.ack = 1'b1;
    goto(smp + 6);
    bus.ack = 1'b0;
    chk("busy_after_ack", int'(bus.busy), 0);
    chk("idle_after_ack", int'(dut.state_q), int'(IDLE));
    goto(smp + 8);
  endtask

  // Start a mode-2 trial, wait until the LED is lit, then pull reset
  // between clock edges.
  task automatic run_abort();
    int lv, d, g;
    lv  = lfsr_at(cyc);
    d   = base_t[2] + ((lv & 'h7FF) & mask_t[2]);
    g   = 1 + TICK_DIV * d;
    pos = 0;
    bus.mode  = 2'd2;
    bus.start = 1'b1;
    goto(1);
    bus.start = 1'b0;
    goto(g + 20);
    chk("led_lit_before_abort", int'(bus.led), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_led", int'(bus.led), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_status", int'(bus.status), 0);
    chk("abort_result", int'(bus.result_ms), 0);
    chk("abort_lfsr", int'(dut.lfsr_q), int'(SEED));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.react = 1'b0;
    bus.ack   = 1'b0;
    #2;
    rst = 1'b0;
    #12;
    chk("reset_led", int'(bus.led), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_status", int'(bus.status), 0);
    chk("reset_result", int'(bus.result_ms), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 100; i++) begin
      chk("idle_outputs", int'({bus.led, bus.busy, bus.done}), 0);
      @(posedge clk);
      #1;
    end
    chk("idle_status", int'(bus.status), 0);
    chk("idle_result", int'(bus.result_ms), 0);

    // mode 2, press 10 ms after the LED (press position within the 10th ms)
    run_trial(2, 0, 39 + int'($urandom_range(0, 3)), 1'b0);
    // mode 0, false start on the 50th ms tick
    run_trial(0, 1, 50 * TICK_DIV, 1'b0);
    // mode 1, no press: too slow at 1000 ms
    run_trial(1, 2, 0, 1'b0);
    // mode 3 (as 2), start glitches while waiting, press on the limit tick
    run_trial(3, 0, TICK_DIV * 500 - 1, 1'b1);
    // mode 2, press on the exact cycle the wait expires
    run_trial(2, 1, 32'h7FFF_FFFF, 1'b0);

    for (int t = 0; t < 3; t++) begin
      if ($urandom_range(0, 1) == 1)
        run_trial(int'($urandom_range(2, 3)), 0, int'($urandom_range(0, 200)), 1'b0);
      else
        run_trial(int'($urandom_range(0, 3)), 1, int'($urandom_range(1, 400)), 1'b0);
    end

    run_abort();
    run_trial(2, 0, int'($urandom_range(0, 60)), 1'b0);

    chk("pending_expects", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reaction_core.md
Name: reaction_core

Overview:
Game engine that consumes the menu's `select`/`mode` outputs and runs one reaction trial.
- On start, waits a pseudo-random, mode-dependent delay, then lights the stimulus LED.
- Measures the time in milliseconds until the player's react press.
- Reports the result (ok / false start / too slow) and holds it until acknowledged, handing control back to the menu.
- Sits between the menu/button logic and the seven-segment display driver.

Parameters:
- TICK_DIV, 100000, clk cycles per millisecond tick (bench overrides to 4).
- LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit delay LFSR.
- MAX_MS, 9999, saturation value of result_ms (display limit).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  menu select level; a trial begins on its rising edge
- mode  in  2  difficulty 0..2; 3 is treated as 2; sampled on the start edge
- react  in  1  debounced one-cycle button pulse
- ack  in  1  one-cycle pulse; clears the held result
- led  out  1  stimulus light
- busy  out  1  high in ARMED and GO
- done  out  1  one-cycle pulse on entry to SHOW
- status  out  2  0=OK, 1=FALSE_START, 2=TOO_SLOW, 3 unused
- result_ms  out  14  reaction time in ms, valid in SHOW

Behaviour:
- Reset (rst low, async): state IDLE; led=0, busy=0, done=0, status=0, result_ms=0; LFSR=LFSR_SEED; prescaler=0; ms counter=0. Reset mid-trial aborts immediately; no done pulse.
- The LFSR is 16-bit Galois, taps 16,14,13,11, and advances every clk in every state.
- start_d is registered each clk; the start edge is start & ~start_d. Edges outside IDLE are ignored.
- Per-mode constants (ms), given as base, mask, limit:
  - mode 0: 2000, 2047, MAX_MS
  - mode 1: 1000, 2047, 1000
  - mode 2: 500, 1023, 500
- IDLE -> ARMED on the start edge:
  - latch mode;
  - delay_ms = base + (lfsr[10:0] & mask);
  - clear prescaler and ms counter.
- Millisecond tick: the prescaler counts 0..TICK_DIV-1; tick is high when it equals TICK_DIV-1. The prescaler and ms counter clear on every state change, so the first tick occurs TICK_DIV cycles after entry.
- ARMED:
  - ms counter increments on tick.
  - react -> SHOW with status=1, result_ms=0. react has priority over delay expiry in the same cycle.
  - On the cycle the counter reaches delay_ms -> GO, led=1 from the next cycle.
- GO:
  - ms counter increments on tick, saturating at MAX_MS.
  - react -> SHOW with status=0, result_ms=current counter (0 if pressed before the first tick).
  - Counter reaching limit with no react -> SHOW with status=2, result_ms=limit.
  - react in the same cycle as limit wins (status=0, result=limit).
- SHOW: led=0, busy=0; done pulses on the first SHOW cycle only; status and result_ms hold.
  - ack -> IDLE. Outputs keep their values until the next trial start overwrites them.
  - react and start in SHOW are ignored.
- All outputs are registered. Latency from react to done = 1 clk.

Decomposition:
- Package reaction_pkg holds:
  - state enum IDLE/ARMED/GO/SHOW;
  - status codes ST_OK/ST_FALSE/ST_SLOW;
  - per-mode base/mask/limit constant functions;
  - LFSR tap mask.
- Sub-module ms_tick_gen holds the prescaler, with ports clk, rst, clr, tick and parameter TICK_DIV.

Test Plan (TICK_DIV=4):
- Reset then idle 100 cycles -> led=0, busy=0, done never pulses, result_ms=0, status=0.
- mode=2, start rises -> busy=1 next cycle; led rises after 500..1523 ticks; react 10 ticks after led -> done pulse, status=0, result_ms=10.
- mode=0, react while ARMED at tick 50 -> status=1, result_ms=0, led never lit.
- mode=1, no react after led -> after 1000 ticks status=2, result_ms=1000; hold until ack, then busy=0 and state IDLE.
- Start edge and glitching start while ARMED, plus react coincident with limit tick -> no retrigger; status=0, result=limit.
- Async rst low in GO with led=1 -> led=0, busy=0 immediately without clk; LFSR equals LFSR_SEED; no done pulse.
